// File: rtl/mux_nto1_seq.sv
// ---------------------------------------------------------------------------
// mux_nto1_seq
// Registered N-to-1 multiplexer with two selection modes:
//   direct    : the channel named by sel is sampled every cycle
//   auto-scan : an internal counter walks channels 0..N-1, holding each one
//               for dwell+1 cycles, and pulses wrap when it returns to 0
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    N packed channels, channel k at [k*W +: W]
//   sel        direct-mode channel select
//   mode       0 = direct, 1 = auto-scan
//   dwell      extra cycles each channel is held while scanning
//   en         sampling enable; low parks the block in IDLE
//   out_data   registered selected data
//   out_valid  out_data was updated on the last edge
//   cur_sel    channel that produced out_data
//   wrap       one-cycle pulse when the scan returns from N-1 to 0
//   sel_err    registered direct-mode sel was out of range (>= N)
// ---------------------------------------------------------------------------
module mux_nto1_seq #(
   parameter  int N  = 4,
   parameter  int W  = 1,
   parameter  int DW = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N*W-1:0] in_data,
   input  logic [SW-1:0]  sel,
   input  logic           mode,
   input  logic [DW-1:0]  dwell,
   input  logic           en,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   output logic [SW-1:0]  cur_sel,
   output logic           wrap,
   output logic           sel_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   localparam int        NSLOT = 2 ** SW;
   localparam logic [SW:0] NVAL = (SW + 1)'(N);

   state_t          state_q, state_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic [SW-1:0]   cur_sel_q, cur_sel_d;
   logic            wrap_q, wrap_d;
   logic            sel_err_q, sel_err_d;
   logic [SW-1:0]   ch_q, ch_d;
   logic [DW-1:0]   dc_q, dc_d;
   logic            sel_oob;

   // Unpack the channels into a power-of-two table. Slots at or above N
   // read as zero, so an out-of-range direct select yields 0 without an
   // extra mux stage.
   logic [W-1:0] chan [NSLOT];

   generate
      for (genvar gi = 0; gi < NSLOT; gi++) begin : g_chan
         if (gi < N) begin : g_real
            assign chan[gi] = in_data[gi*W +: W];
         end else begin : g_pad
            assign chan[gi] = '0;
         end
      end
   endgenerate

   assign sel_oob = ({1'b0, sel} >= NVAL);

   always_comb begin
      // Defaults: hold everything, no valid, no wrap.
      state_d     = ST_IDLE;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      cur_sel_d   = cur_sel_q;
      wrap_d      = 1'b0;
      sel_err_d   = sel_err_q;
      ch_d        = ch_q;
      dc_d        = dc_q;

      if (en) begin
         state_d = mode ? ST_SCAN : ST_DIRECT;
      end

      // Outputs are produced for the state being entered on this edge, so
      // the first cycle in a new mode already carries valid data.
      case (state_d)
         ST_DIRECT: begin
            out_data_d  = chan[sel];
            cur_sel_d   = sel;
            sel_err_d   = sel_oob;
            out_valid_d = 1'b1;
         end
         ST_SCAN: begin
            if (state_q != ST_SCAN) begin
               // Any entry restarts the scan; this edge counts as the
               // first hold cycle of channel 0.
               ch_d = '0;
               dc_d = '0;
            end else if (dc_q < dwell) begin
               dc_d = dc_q + DW'(1);
            end else begin
               // >= rather than == so a lowered dwell advances immediately.
               dc_d = '0;
               if (ch_q == SW'(N - 1)) begin
                  ch_d   = '0;
                  wrap_d = 1'b1;
               end else begin
                  ch_d = ch_q + SW'(1);
               end
            end
            out_data_d  = chan[ch_d];
            cur_sel_d   = ch_d;
            sel_err_d   = 1'b0;
            out_valid_d = 1'b1;
         end
         default: begin
            // IDLE: hold data/select/error and freeze the scan counters.
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         cur_sel_q   <= '0;
         wrap_q      <= 1'b0;
         sel_err_q   <= 1'b0;
         ch_q        <= '0;
         dc_q        <= '0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         cur_sel_q   <= cur_sel_d;
         wrap_q      <= wrap_d;
         sel_err_q   <= sel_err_d;
         ch_q        <= ch_d;
         dc_q        <= dc_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign cur_sel   = cur_sel_q;
   assign wrap      = wrap_q;
   assign sel_err   = sel_err_q;

endmodule
